// File: rtl/bus_align_splitter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_align_splitter_pkg
// Purpose  : Shared bus encodings and alignment helpers for the femto bus.
//            Responders reuse the same helpers for their own fault checks.
// Revision : 1.0 - initial release
// ============================================================================
package bus_align_splitter_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;

  // Access size encodings carried on u_acc / d_acc
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  // Number of bytes moved by an access size; unknown codes are treated as 4B
  function automatic logic [2:0] bus_acc_bytes(input logic [BUS_ACC_WIDTH-1:0] acc);
    logic [2:0] n;
    case (acc)
      BUS_ACC_1B: n = 3'd1;
      BUS_ACC_2B: n = 3'd2;
      default:    n = 3'd4;
    endcase
    return n;
  endfunction

  // True when the access is not naturally aligned to its own size
  function automatic logic bus_misaligned(input logic [1:0]               addr_lo,
                                          input logic [BUS_ACC_WIDTH-1:0] acc);
    logic mis;
    case (acc)
      BUS_ACC_1B: mis = 1'b0;
      BUS_ACC_2B: mis = addr_lo[0];
      default:    mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_align_splitter.sv
`default_nettype none
// ============================================================================
// Module   : bus_align_splitter
// Purpose  : Turns upstream accesses of any alignment into naturally aligned
//            downstream transactions. Misaligned 2B/4B accesses become a run
//            of 1B transactions reassembled little-endian. Each downstream
//            transaction is guarded by a response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bus_align_splitter
  import bus_align_splitter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ADDR_WIDTH-1:0]    u_addr,
  input  logic                     u_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] u_acc,
  input  logic [BUS_WIDTH-1:0]     u_wdata,
  input  logic                     u_req,
  output logic [BUS_WIDTH-1:0]     u_rdata,
  output logic                     u_resp,
  output logic                     u_fault,
  output logic                     busy,
  output logic [ADDR_WIDTH-1:0]    d_addr,
  output logic                     d_w_rb,
  output logic [BUS_ACC_WIDTH-1:0] d_acc,
  output logic [BUS_WIDTH-1:0]     d_wdata,
  output logic                     d_req,
  input  logic [BUS_WIDTH-1:0]     d_rdata,
  input  logic                     d_resp,
  input  logic                     d_fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Timeout counter only needs to reach TIMEOUT-1 before firing
  localparam int            TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIMIT = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t                   r_state, w_next;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic                     r_w_rb;
  logic [BUS_ACC_WIDTH-1:0] r_acc;
  logic [BUS_WIDTH-1:0]     r_wdata;
  logic                     r_split;
  logic [1:0]               r_idx;
  logic [1:0]               r_last;
  logic [BUS_WIDTH-1:0]     r_asm;
  logic [TW-1:0]            r_tcnt;

  logic                     w_accept, w_resp_ok, w_done, w_abort;
  logic [ADDR_WIDTH-1:0]    w_src_addr, w_sub_addr;
  logic                     w_src_w_rb, w_src_split;
  logic [BUS_ACC_WIDTH-1:0] w_src_acc, w_sub_acc;
  logic [BUS_WIDTH-1:0]     w_src_wdata, w_sub_wdata;
  logic [1:0]               w_src_idx;
  logic [BUS_WIDTH-1:0]     w_mask, w_asm_next;

  assign busy = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; a response in WAIT takes priority over the timeout
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_resp_ok = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (u_req) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (d_fault) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (d_resp) begin
          w_resp_ok = 1'b1;
          if (r_idx == r_last) begin
            w_done = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_next = S_ISSUE;
          end
        end else if ((TIMEOUT != 0) && (r_tcnt == TLIMIT)) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Build the next downstream transaction and the next assembly value
  always_comb begin
    w_src_addr  = w_accept ? u_addr  : r_addr;
    w_src_w_rb  = w_accept ? u_w_rb  : r_w_rb;
    w_src_acc   = w_accept ? u_acc   : r_acc;
    w_src_wdata = w_accept ? u_wdata : r_wdata;
    w_src_split = w_accept ? bus_misaligned(u_addr[1:0], u_acc) : r_split;
    w_src_idx   = w_accept ? 2'd0 : (r_idx + 2'd1);

    w_sub_addr  = w_src_addr;
    w_sub_acc   = w_src_acc;
    w_sub_wdata = w_src_wdata;
    if (w_src_split) begin
      w_sub_addr  = w_src_addr + ADDR_WIDTH'(w_src_idx);
      w_sub_acc   = BUS_ACC_1B;
      w_sub_wdata = {24'd0, w_src_wdata[{w_src_idx, 3'b000} +: 8]};
    end

    case (r_acc)
      BUS_ACC_1B: w_mask = 32'h0000_00FF;
      BUS_ACC_2B: w_mask = 32'h0000_FFFF;
      default:    w_mask = 32'hFFFF_FFFF;
    endcase

    w_asm_next = r_asm;
    if (r_split) w_asm_next[{r_idx, 3'b000} +: 8] = d_rdata[7:0];
    else         w_asm_next = d_rdata & w_mask;
  end

  // Request capture, downstream drive, timeout count and upstream completion
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_w_rb  <= 1'b0;
      r_acc   <= '0;
      r_wdata <= '0;
      r_split <= 1'b0;
      r_idx   <= 2'd0;
      r_last  <= 2'd0;
      r_asm   <= '0;
      r_tcnt  <= '0;
      d_addr  <= '0;
      d_w_rb  <= 1'b0;
      d_acc   <= '0;
      d_wdata <= '0;
      d_req   <= 1'b0;
      u_rdata <= '0;
      u_resp  <= 1'b0;
      u_fault <= 1'b0;
    end else begin
      d_req   <= (w_next == S_ISSUE);
      u_resp  <= w_done;
      u_fault <= w_abort;

      if (w_accept) begin
        r_addr  <= u_addr;
        r_w_rb  <= u_w_rb;
        r_acc   <= u_acc;
        r_wdata <= u_wdata;
        r_split <= bus_misaligned(u_addr[1:0], u_acc);
        r_last  <= bus_misaligned(u_addr[1:0], u_acc) ? 2'(bus_acc_bytes(u_acc) - 3'd1) : 2'd0;
        r_asm   <= '0;
      end

      if (w_next == S_ISSUE) begin
        r_idx   <= w_src_idx;
        d_addr  <= w_sub_addr;
        d_w_rb  <= w_src_w_rb;
        d_acc   <= w_sub_acc;
        d_wdata <= w_sub_wdata;
      end

      if (r_state == S_ISSUE)                 r_tcnt <= '0;
      else if ((r_state == S_WAIT) && !d_resp) r_tcnt <= r_tcnt + TW'(1);

      if (w_resp_ok && !r_w_rb) r_asm   <= w_asm_next;
      if (w_done)               u_rdata <= r_w_rb ? '0 : w_asm_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_align_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_align_splitter
// Purpose  : Self-checking bench for bus_align_splitter with a byte-memory
//            responder (ROM window 0x200-0x2FF faults on writes) and a
//            reference model working on byte addresses and queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_align_splitter;
  import bus_align_splitter_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic        w;
    logic [1:0]  acc;
    logic [31:0] wd;
  } tx_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] u_addr;
  logic        u_w_rb;
  logic [1:0]  u_acc;
  logic [31:0] u_wdata;
  logic        u_req;
  logic [31:0] u_rdata;
  logic        u_resp, u_fault, busy;
  logic [31:0] d_addr;
  logic        d_w_rb;
  logic [1:0]  d_acc;
  logic [31:0] d_wdata;
  logic        d_req;
  logic [31:0] d_rdata = 32'h0;
  logic        d_resp  = 1'b0;
  logic        d_fault;

  int errors = 0;
  int checks = 0;
  int resp_delay = 1;     // responder latency in cycles; 0 = never responds

  tx_t        txq[$];     // transactions seen on the downstream bus
  tx_t        expq[$];    // transactions the model expects
  logic [7:0] mem[logic [31:0]];
  logic [7:0] ref_mem[logic [31:0]];

  bus_align_splitter #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .u_addr(u_addr), .u_w_rb(u_w_rb), .u_acc(u_acc), .u_wdata(u_wdata), .u_req(u_req),
    .u_rdata(u_rdata), .u_resp(u_resp), .u_fault(u_fault), .busy(busy),
    .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc), .d_wdata(d_wdata), .d_req(d_req),
    .d_rdata(d_rdata), .d_resp(d_resp), .d_fault(d_fault)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] acc);
    return (acc == BUS_ACC_1B) ? 1 : (acc == BUS_ACC_2B) ? 2 : 4;
  endfunction

  function automatic logic [7:0] pat(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  function automatic logic rom_hit(input logic [31:0] a, input logic [1:0] acc);
    logic        hit;
    logic [31:0] b;
    hit = 1'b0;
    for (int k = 0; k < nbytes(acc); k++) begin
      b = a + 32'(k);
      if (b >= 32'h200 && b <= 32'h2FF) hit = 1'b1;
    end
    return hit;
  endfunction

  assign d_fault = d_req & d_w_rb & rom_hit(d_addr, d_acc);

  // Responder: logs every d_req, performs writes, answers after resp_delay cycles
  logic pend = 1'b0;
  int   cnt  = 0;
  tx_t  ptx;
  always @(negedge clk) begin
    tx_t t;
    d_resp = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        pend    = 1'b0;
        d_resp  = 1'b1;
        d_rdata = $urandom;
        if (!ptx.w)
          for (int k = 0; k < nbytes(ptx.acc); k++) d_rdata[8*k +: 8] = mem_rd(ptx.a + 32'(k));
      end else begin
        cnt--;
      end
    end
    if (d_req) begin
      t.a = d_addr; t.w = d_w_rb; t.acc = d_acc; t.wd = d_wdata;
      txq.push_back(t);
      if (!d_fault && resp_delay != 0) begin
        pend = 1'b1;
        cnt  = resp_delay - 1;
        ptx  = t;
        if (t.w)
          for (int k = 0; k < nbytes(t.acc); k++) mem[t.a + 32'(k)] = t.wd[8*k +: 8];
      end
    end
  end

  // Reference model: expected transaction list, read result and fault outcome
  task automatic model(input logic [31:0] a, input logic wr, input logic [1:0] acc,
                       input logic [31:0] wd, output logic [31:0] erd, output logic ef);
    int  n;
    tx_t t;
    n = nbytes(acc);
    expq.delete();
    ef  = 1'b0;
    erd = 32'h0;
    if ((a % 32'(n)) == 0) begin
      t.a = a; t.w = wr; t.acc = acc; t.wd = wd;
      expq.push_back(t);
    end else begin
      for (int k = 0; k < n; k++) begin
        t.a = a + 32'(k); t.w = wr; t.acc = BUS_ACC_1B; t.wd = (wd >> (8*k)) & 32'hFF;
        expq.push_back(t);
      end
    end
    for (int j = 0; j < expq.size(); j++) begin
      if (expq[j].w && rom_hit(expq[j].a, expq[j].acc)) begin
        ef = 1'b1;
        while (expq.size() > j + 1) void'(expq.pop_back());
        break;
      end
      if (expq[j].w)
        for (int b = 0; b < nbytes(expq[j].acc); b++)
          ref_mem[expq[j].a + 32'(b)] = expq[j].wd[8*b +: 8];
    end
    if (!ef && !wr)
      for (int k = 0; k < n; k++) erd[8*k +: 8] = ref_rd(a + 32'(k));
  endtask

  function automatic logic txq_matches();
    if (txq.size() != expq.size()) return 1'b0;
    for (int k = 0; k < txq.size(); k++) if (txq[k] !== expq[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Issue one upstream access and wait (bounded) for u_resp or u_fault
  task automatic do_access(input logic [31:0] a, input logic wr, input logic [1:0] acc,
                           input logic [31:0] wd, output logic [31:0] rd, output int lat,
                           output logic gr, output logic gf);
    txq.delete();
    u_addr = a; u_w_rb = wr; u_acc = acc; u_wdata = wd; u_req = 1'b1;
    @(posedge clk); #1;
    u_req = 1'b0;
    rd = 32'h0; lat = -1; gr = 1'b0; gf = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (u_resp || u_fault) begin
        gr = u_resp; gf = u_fault; lat = k; rd = u_rdata;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    u_addr = 32'h0; u_w_rb = 1'b0; u_acc = 2'd0; u_wdata = 32'h0; u_req = 1'b0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, d_req, u_resp, u_fault} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/d_req/u_resp/u_fault=%b expected 0000", {busy, d_req, u_resp, u_fault});
    end
    checks++;
    if ({u_rdata, d_addr, d_wdata, d_acc, d_w_rb} !== 99'b0) begin
      errors++;
      $display("FAIL reset_data: got u_rdata=%h d_addr=%h d_wdata=%h expected all 0", u_rdata, d_addr, d_wdata);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned_read();
    logic [31:0] rd; int lat; logic gr, gf;
    poke(32'h100, 8'h44); poke(32'h101, 8'h33); poke(32'h102, 8'h22); poke(32'h103, 8'h11);
    resp_delay = 1;
    do_access(32'h100, 1'b0, BUS_ACC_4B, 32'h0, rd, lat, gr, gf);
    checks++;
    if (!gr || gf || lat != 3) begin
      errors++;
      $display("FAIL aligned_lat: got resp=%b fault=%b lat=%0d expected 1 0 3", gr, gf, lat);
    end
    checks++;
    if (rd !== 32'h11223344) begin
      errors++;
      $display("FAIL aligned_rdata: got %h expected 11223344", rd);
    end
    checks++;
    if (!(txq.size() == 1 && txq[0].a == 32'h100 && txq[0].acc == BUS_ACC_4B)) begin
      errors++;
      $display("FAIL aligned_tx: got %0d transactions expected one 4B at 0x100", txq.size());
    end
  endtask

  task automatic test_misaligned_read();
    logic [31:0] rd; int lat; logic gr, gf; logic ok;
    poke(32'h101, 8'hAA); poke(32'h102, 8'hBB); poke(32'h103, 8'hCC); poke(32'h104, 8'hDD);
    do_access(32'h101, 1'b0, BUS_ACC_4B, 32'h0, rd, lat, gr, gf);
    checks++;
    if (!gr || gf || lat != 9) begin
      errors++;
      $display("FAIL split_lat: got resp=%b fault=%b lat=%0d expected 1 0 9", gr, gf, lat);
    end
    checks++;
    if (rd !== 32'hDDCCBBAA) begin
      errors++;
      $display("FAIL split_rdata: got %h expected ddccbbaa", rd);
    end
    ok = (txq.size() == 4);
    for (int k = 0; k < 4; k++)
      if (ok && (txq[k].a != 32'h101 + 32'(k) || txq[k].acc != BUS_ACC_1B)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL split_tx: got %0d transactions expected 4 1B at 0x101..0x104", txq.size());
    end
    @(posedge clk); #1;
    checks++;
    if (u_rdata !== 32'hDDCCBBAA || u_resp !== 1'b0) begin
      errors++;
      $display("FAIL rdata_hold: got u_rdata=%h u_resp=%b expected ddccbbaa 0", u_rdata, u_resp);
    end
  endtask

  task automatic test_rom_fault();
    logic [31:0] rd; int lat; logic gr, gf; logic late;
    do_access(32'h203, 1'b1, BUS_ACC_2B, 32'h5A6B, rd, lat, gr, gf);
    checks++;
    if (gr || !gf || lat != 2) begin
      errors++;
      $display("FAIL rom_fault: got resp=%b fault=%b lat=%0d expected 0 1 2", gr, gf, lat);
    end
    late = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (u_resp || u_fault) late = 1'b1;
    end
    checks++;
    if (late || !(txq.size() == 1 && txq[0].a == 32'h203 && txq[0].wd == 32'h6B)) begin
      errors++;
      $display("FAIL rom_abort: got %0d transactions extra_pulse=%b expected one (0x203,0x6b) and none", txq.size(), late);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; int lat; logic gr, gf;
    resp_delay = 0;
    do_access(32'h1000, 1'b0, BUS_ACC_4B, 32'h0, rd, lat, gr, gf);
    checks++;
    if (gr || !gf || lat != 6) begin
      errors++;
      $display("FAIL timeout: got resp=%b fault=%b lat=%0d expected 0 1 6", gr, gf, lat);
    end
    checks++;
    if (busy !== 1'b0 || txq.size() != 1) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b tx=%0d expected 0 1", busy, txq.size());
    end
    resp_delay = 1;
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int lat; logic gr, gf;
    poke(32'hFFFF_FFFF, 8'h12); poke(32'h0, 8'h34);
    do_access(32'hFFFF_FFFF, 1'b0, BUS_ACC_2B, 32'h0, rd, lat, gr, gf);
    checks++;
    if (!gr || lat != 5 || rd !== 32'h3412) begin
      errors++;
      $display("FAIL wrap_rdata: got %h lat=%0d expected 00003412 5", rd, lat);
    end
    checks++;
    if (!(txq.size() == 2 && txq[0].a == 32'hFFFF_FFFF && txq[1].a == 32'h0)) begin
      errors++;
      $display("FAIL wrap_addr: got %0d transactions expected ffffffff then 00000000", txq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd; int lat; logic gr, gf, ef;
    model(32'h104, 1'b0, BUS_ACC_4B, 32'h0, erd, ef);
    do_access(32'h104, 1'b0, BUS_ACC_4B, 32'h0, rd, lat, gr, gf);
    checks++;
    if (!gr || lat != 3 || rd !== erd) begin
      errors++;
      $display("FAIL b2b_first: got %h lat=%0d expected %h 3", rd, lat, erd);
    end
    model(32'h1004, 1'b1, BUS_ACC_4B, 32'hCAFE_F00D, erd, ef);
    do_access(32'h1004, 1'b1, BUS_ACC_4B, 32'hCAFE_F00D, rd, lat, gr, gf);
    checks++;
    if (!gr || lat != 3 || rd !== 32'h0 || !txq_matches()) begin
      errors++;
      $display("FAIL b2b_second: got resp=%b lat=%0d rdata=%h tx=%0d expected 1 3 0 1", gr, lat, rd, txq.size());
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] erd; logic ef; int lat;
    resp_delay = 2;
    model(32'h100, 1'b0, BUS_ACC_4B, 32'h0, erd, ef);
    txq.delete();
    u_addr = 32'h100; u_w_rb = 1'b0; u_acc = BUS_ACC_4B; u_req = 1'b1;
    @(posedge clk); #1;
    u_addr = 32'h1234; u_w_rb = 1'b1; u_wdata = 32'hFFFF_FFFF;   // held high through ISSUE and WAIT
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) u_req = 1'b0;
      if (u_resp) begin lat = k; break; end
      @(posedge clk); #1;
    end
    u_req = 1'b0;
    checks++;
    if (lat != 4 || u_rdata !== erd) begin
      errors++;
      $display("FAIL busy_ignore: got lat=%0d rdata=%h expected 4 %h", lat, u_rdata, erd);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || txq.size() != 1) begin
      errors++;
      $display("FAIL busy_ignore_tx: got busy=%b tx=%0d expected 0 1", busy, txq.size());
    end
    resp_delay = 1;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd, erd; int lat; logic gr, gf, ef, late;
    resp_delay = 3;
    u_addr = 32'h1000; u_w_rb = 1'b0; u_acc = BUS_ACC_4B; u_req = 1'b1;
    @(posedge clk); #1;
    u_req = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, d_req, u_resp, u_fault} !== 4'b0 || u_rdata !== 32'h0 || d_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_wait: got busy=%b d_req=%b u_rdata=%h d_addr=%h expected all 0", busy, d_req, u_rdata, d_addr);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    late = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (u_resp || u_fault || busy) late = 1'b1;
    end
    checks++;
    if (late) begin
      errors++;
      $display("FAIL late_resp: got activity after reset expected none");
    end
    resp_delay = 1;
    model(32'h1000, 1'b0, BUS_ACC_4B, 32'h0, erd, ef);
    do_access(32'h1000, 1'b0, BUS_ACC_4B, 32'h0, rd, lat, gr, gf);
    checks++;
    if (!gr || lat != 3 || rd !== erd) begin
      errors++;
      $display("FAIL post_reset: got %h lat=%0d expected %h 3", rd, lat, erd);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, erd; logic [1:0] acc; logic wr, gr, gf, ef, memok;
    int lat, elat, d;
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h1000 + 32'($urandom_range(0, 31));
        1:       a = 32'h2F8 + 32'($urandom_range(0, 15));
        2:       a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        default: a = $urandom;
      endcase
      acc = 2'($urandom_range(0, 2));
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      d   = int'($urandom_range(1, 3));
      resp_delay = d;
      model(a, wr, acc, wd, erd, ef);
      do_access(a, wr, acc, wd, rd, lat, gr, gf);
      elat = ef ? 2 + (expq.size() - 1) * (1 + d) : 1 + expq.size() * (1 + d);
      checks++;
      if (gr !== !ef || gf !== ef) begin
        errors++;
        $display("FAIL rnd_outcome: addr=%h acc=%0d wr=%b got resp=%b fault=%b expected fault=%b", a, acc, wr, gr, gf, ef);
      end
      checks++;
      if (lat != elat) begin
        errors++;
        $display("FAIL rnd_latency: addr=%h acc=%0d got %0d expected %0d", a, acc, lat, elat);
      end
      checks++;
      if (!txq_matches()) begin
        errors++;
        $display("FAIL rnd_tx: addr=%h acc=%0d got %0d transactions expected %0d", a, acc, txq.size(), expq.size());
      end
      if (gr) begin
        checks++;
        if (rd !== erd) begin
          errors++;
          $display("FAIL rnd_rdata: addr=%h acc=%0d wr=%b got %h expected %h", a, acc, wr, rd, erd);
        end
      end
      if (wr) begin
        memok = 1'b1;
        for (int k = 0; k < nbytes(acc); k++) if (mem_rd(a + 32'(k)) !== ref_rd(a + 32'(k))) memok = 1'b0;
        checks++;
        if (!memok) begin
          errors++;
          $display("FAIL rnd_mem: addr=%h acc=%0d got memory differing from expected", a, acc);
        end
      end
    end
    resp_delay = 1;
  endtask

  initial begin
    test_reset();
    test_aligned_read();
    test_misaligned_read();
    test_rom_fault();
    test_timeout();
    test_wrap();
    test_back_to_back();
    test_busy_ignore();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_align_splitter.md
Name: bus_align_splitter

Overview:
- Bus-initiator-side adapter between a master (core load/store unit or debug port) and the femto slave bus.
- Accepts upstream accesses of any alignment and issues only naturally aligned downstream transactions, so no responder ever raises an alignment fault.
- Aligned accesses pass through as one transaction; misaligned 2B/4B accesses are split into sequential 1B transactions and reassembled little-endian.
- Adds a per-transaction response timeout so a silent responder cannot hang the master.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- TIMEOUT, 255, cycles to wait for d_resp after d_req; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- u_addr  in  ADDR_WIDTH  upstream byte address
- u_w_rb  in  1  1=write, 0=read
- u_acc  in  `BUS_ACC_WIDTH  access size (`BUS_ACC_1B/2B/4B)
- u_wdata  in  `BUS_WIDTH  write data, right-justified
- u_req  in  1  single-cycle request pulse
- u_rdata  out  `BUS_WIDTH  read data, right-justified, zero-extended
- u_resp  out  1  single-cycle completion pulse
- u_fault  out  1  single-cycle fault pulse
- busy  out  1  transaction in progress
- d_addr  out  ADDR_WIDTH  downstream address
- d_w_rb  out  1  downstream write/read
- d_acc  out  `BUS_ACC_WIDTH  downstream size
- d_wdata  out  `BUS_WIDTH  downstream write data, right-justified
- d_req  out  1  downstream request pulse
- d_rdata  in  `BUS_WIDTH  downstream read data, right-justified
- d_resp  in  1  downstream completion, earliest one cycle after d_req
- d_fault  in  1  downstream fault, valid only in the d_req cycle

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low.
- Reset values:
  - All outputs 0; state IDLE.
  - Reset mid-transaction aborts with no u_resp or u_fault.
  - Any d_resp arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - u_req captures addr, w_rb, acc and wdata; go to ISSUE.
  - Misaligned means addr[0]=1 with acc≠1B, or addr[1:0]≠0 with acc=4B.
  - Sub-access count N is 1 if aligned, otherwise 2 (2B) or 4 (4B), each sub-access 1B.
  - Clear the assembly register and set index i=0.
- ISSUE:
  - d_req=1 for exactly one cycle. All d_* outputs are registered and held stable from ISSUE through WAIT.
  - Aligned: d_addr=addr, d_acc=acc, d_wdata=wdata.
  - Split: d_addr=addr+i (wraps modulo 2^ADDR_WIDTH), d_acc=1B, d_wdata={24'd0, wdata[8i+:8]}.
  - d_fault=1 in this cycle: abort and go to IDLE; u_fault=1 next cycle.
  - Otherwise go to WAIT and clear the timeout counter.
- WAIT:
  - On d_resp, for reads:
    - Split: store d_rdata[7:0] into byte i of the assembly register.
    - Aligned: store d_rdata masked to the acc width (upper bytes zeroed).
  - If i=N-1: go to IDLE; u_resp=1 next cycle with u_rdata valid.
  - Otherwise: i+1, go to ISSUE.
  - d_fault is ignored in WAIT.
  - Timeout: counter increments each WAIT cycle without d_resp. When it reaches TIMEOUT (TIMEOUT≠0): go to IDLE; u_fault=1 next cycle.
- Fault semantics:
  - Any sub-access fault aborts the remaining sub-accesses. u_fault pulses; u_resp does not.
  - Split writes are non-atomic: bytes already completed stay written.
- Output timing:
  - u_resp and u_fault are registered, mutually exclusive, one-cycle pulses.
  - u_rdata holds its value until the next completion. It is 0 for writes.
- busy=1 in ISSUE and WAIT.
- u_req while busy is a protocol violation; it is ignored.
- u_req in the cycle u_resp or u_fault is high (state IDLE) is accepted, giving back-to-back operation.
- Latency with 1-cycle responders: u_resp arrives 1+2N cycles after u_req (aligned: 3 cycles; misaligned 4B: 9 cycles).

Decomposition:
- Shared header femto.vh: add `BUS_ACC_BYTES(acc) macro (1/2/4) and an alignment-check macro, reused by responders for fault generation.
- State encodings stay local to the module.
- No sub-module is needed; the timeout counter stays inline.

Test Plan:
- Aligned 4B read, addr=0x100, ROM word 0x11223344 -> d_req once with d_acc=4B; u_resp 3 cycles after u_req; u_rdata=0x11223344.
- Misaligned 4B read, addr=0x101, ROM bytes 0x101..0x104 = AA BB CC DD -> four 1B d_req at 0x101..0x104; u_rdata=0xDDCCBBAA; u_resp at cycle 9.
- Misaligned 2B write to the ROM, addr=0x203, wdata=0x5A6B -> first d_req (0x203, wdata 0x6B) sees d_fault -> u_fault pulses 2 cycles after u_req; no second d_req; no u_resp.
- TIMEOUT=4, responder never asserts d_resp -> u_fault exactly 4 WAIT cycles after d_req; busy drops.
- Wrap: addr=0xFFFFFFFF, 2B read -> d_addr 0xFFFFFFFF then 0x00000000; bytes assembled low-then-high.
- Reset asserted in WAIT, then a late d_resp after release -> outputs 0 immediately; no u_resp; the next u_req completes normally.
